// File: rtl/mac_scheduler_if.sv
// Handshake and sequencing bundle between the MAC scheduler and the equalizer datapath.
// "master" is the scheduler side; "slave" is the sample source / datapath side.
interface mac_scheduler_if #(
  parameter int unsigned TAPS  = 64,
  parameter int unsigned BANDS = 8
);
  localparam int unsigned TapW  = $clog2(TAPS);
  localparam int unsigned BandW = $clog2(BANDS);

  logic             in_valid;
  logic             in_ready;
  logic             shift_en;
  logic [TapW-1:0]  tap_addr;
  logic [BandW-1:0] band_sel;
  logic             clk_enable;
  logic             phase_0;
  logic             phase_last;
  logic             out_strobe;
  logic [BandW-1:0] out_band;
  logic             busy;

  modport master (
    input  in_valid,
    output in_ready, shift_en, tap_addr, band_sel, clk_enable,
           phase_0, phase_last, out_strobe, out_band, busy
  );

  modport slave (
    output in_valid,
    input  in_ready, shift_en, tap_addr, band_sel, clk_enable,
           phase_0, phase_last, out_strobe, out_band, busy
  );
endinterface

// File: rtl/mac_scheduler.sv
// Sequencer for the shared equalizer MAC: accepts a sample, walks every tap of every band,
// then a single drain cycle commits the last band's accumulator.
module mac_scheduler #(
  parameter int unsigned TAPS  = 64,
  parameter int unsigned BANDS = 8
) (
  input logic             clk_i,
  input logic             rst_ni,
  mac_scheduler_if.master sched
);
  localparam int unsigned TapW  = $clog2(TAPS);
  localparam int unsigned BandW = $clog2(BANDS);

  localparam logic [TapW-1:0]  TapLast  = TapW'(TAPS - 1);
  localparam logic [TapW-1:0]  TapOne   = TapW'(1);
  localparam logic [BandW-1:0] BandLast = BandW'(BANDS - 1);
  localparam logic [BandW-1:0] BandOne  = BandW'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q;
  logic [TapW-1:0]  tap_q;
  logic [BandW-1:0] band_q;
  logic [BandW-1:0] out_band_q;
  logic             clk_en_q;
  logic             phase_0_q;
  logic             phase_last_q;
  logic             strobe_q;
  logic             busy_q;
  logic             commit;

  // Every phase_0 closes the previous band, except the very first tap of band 0.
  assign commit = phase_0_q && !(state_q == StRun && band_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      tap_q        <= '0;
      band_q       <= '0;
      out_band_q   <= '0;
      clk_en_q     <= 1'b0;
      phase_0_q    <= 1'b0;
      phase_last_q <= 1'b0;
      strobe_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      strobe_q <= commit;
      // band_q is 0 in DRAIN, so this wraps naturally to BANDS-1 there.
      if (commit) out_band_q <= band_q - BandOne;

      unique case (state_q)
        StIdle: begin
          if (sched.in_valid) begin
            state_q      <= StRun;
            tap_q        <= '0;
            band_q       <= '0;
            clk_en_q     <= 1'b1;
            phase_0_q    <= 1'b1;
            phase_last_q <= (TapLast == '0);
            busy_q       <= 1'b1;
          end
        end
        StRun: begin
          tap_q        <= tap_q + TapOne;
          phase_0_q    <= (tap_q == TapLast);
          phase_last_q <= ((tap_q + TapOne) == TapLast);
          if (tap_q == TapLast) begin
            band_q <= band_q + BandOne;
            if (band_q == BandLast) begin
              state_q  <= StDrain;
              clk_en_q <= 1'b0;
            end
          end
        end
        StDrain: begin
          state_q   <= StIdle;
          phase_0_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sched.in_ready   = (state_q == StIdle);
  // Gated by reset so a sample held during reset is not reported as shifted in.
  assign sched.shift_en   = sched.in_ready && sched.in_valid && rst_ni;
  assign sched.tap_addr   = tap_q;
  assign sched.band_sel   = band_q;
  assign sched.clk_enable = clk_en_q;
  assign sched.phase_0    = phase_0_q;
  assign sched.phase_last = phase_last_q;
  assign sched.out_strobe = strobe_q;
  assign sched.out_band   = out_band_q;
  assign sched.busy       = busy_q;
endmodule

// File: tb/tb_mac_scheduler.sv
// Directed bench for mac_scheduler: default 64x8 instance plus a 4x2 corner instance.
module tb_mac_scheduler;
  localparam int T = 64;
  localparam int B = 8;

  logic clk;
  logic rst_n;
  logic rst_s_n;
  int   checks   = 0;
  int   failures = 0;

  mac_scheduler_if #(.TAPS(T), .BANDS(B)) if_d ();
  mac_scheduler_if #(.TAPS(4), .BANDS(2)) if_s ();

  mac_scheduler #(.TAPS(T), .BANDS(B)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .sched  (if_d)
  );

  mac_scheduler #(.TAPS(4), .BANDS(2)) dut_s (
    .clk_i  (clk),
    .rst_ni (rst_s_n),
    .sched  (if_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] snap();
    return {if_d.tap_addr, if_d.band_sel, if_d.clk_enable, if_d.phase_0, if_d.phase_last,
            if_d.busy, if_d.in_ready, if_d.shift_en, if_d.out_strobe};
  endfunction

  function automatic logic [15:0] mk(int tap, int band, bit ce, bit p0, bit pl, bit bz,
                                     bit rdy, bit sh, bit st);
    return {6'(tap), 3'(band), ce, p0, pl, bz, rdy, sh, st};
  endfunction

  // Entered just after a negedge in an IDLE cycle; mode 0: drop in_valid, 1: hold, 2: random.
  task automatic run_sample(input int mode, input bit st0);
    if_d.in_valid = 1'b1;
    #1;
    check("accept", snap(), mk(0, 0, 0, 0, 0, 0, 1, 1, st0));
    for (int k = 0; k < B; k++) begin
      for (int j = 0; j < T; j++) begin
        @(negedge clk);
        if_d.in_valid = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        check("run", snap(), mk(j, k, 1, j == 0, j == T - 1, 1, 0, 0, j == 1 && k > 0));
        if (j == 1 && k > 0) check("run_band", 32'(if_d.out_band), 32'(k - 1));
      end
    end
    @(negedge clk);
    if_d.in_valid = (mode == 1);
    #1;
    check("drain", snap(), mk(0, 0, 0, 1, 0, 1, 0, 0, 0));
    @(negedge clk);
    #1;
    check("end_idle", snap(), mk(0, 0, 0, 0, 0, 0, 1, mode == 1, 1));
    check("end_band", 32'(if_d.out_band), 32'(B - 1));
  endtask

  int c_tap  [10] = '{0, 0, 1, 2, 3, 0, 1, 2, 3, 0};
  int c_band [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};

  initial begin
    rst_n         = 1'b0;
    rst_s_n       = 1'b0;
    if_d.in_valid = 1'b1;
    if_s.in_valid = 1'b0;
    #12;
    check("reset", snap(), mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    check("reset_band", 32'(if_d.out_band), 32'd0);

    // Single sample, accepted on the first edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    run_sample(0, 0);
    repeat (5) begin
      @(negedge clk);
      #1;
      check("idle", snap(), mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    end

    // Back-to-back, then random in_valid noise during RUN.
    @(negedge clk);
    run_sample(1, 0);
    run_sample(1, 1);
    run_sample(2, 1);

    // Mid-operation reset at band 3, tap 20.
    @(negedge clk);
    if_d.in_valid = 1'b1;
    #1;
    check("mid_accept", 32'(if_d.shift_en), 32'd1);
    repeat (3 * T + 21) begin
      @(negedge clk);
      if_d.in_valid = 1'b0;
    end
    #1;
    check("mid_pos", {26'd0, if_d.tap_addr}, 32'd20);
    check("mid_band", 32'(if_d.band_sel), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset", snap(), mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      #1;
      check("post_reset", snap(), mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    end
    @(negedge clk);
    run_sample(0, 0);

    // Corner instance: TAPS=4, BANDS=2, in_valid held for two samples.
    @(negedge clk);
    rst_s_n       = 1'b1;
    if_s.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      check("s_tap", 32'(if_s.tap_addr), 32'(c_tap[i % 10]));
      check("s_band", 32'(if_s.band_sel), 32'(c_band[i % 10]));
      check("s_shift", 32'(if_s.shift_en), 32'(i % 10 == 0));
      check("s_strobe", 32'(if_s.out_strobe), 32'(i == 10 || i % 10 == 6));
      if (i == 10 || i % 10 == 6) check("s_out_band", 32'(if_s.out_band), 32'(i % 10 != 6));
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
